// File: rtl/image_ycbcr422_ycbcr444.sv
// Chroma upsampler: 4:2:2 (Y + interleaved Cb/Cr) to 4:4:4 by nearest-neighbour chroma replication.
// Latency: framing delayed 2 clk; each pixel strobes 1 clk after the edge that completes its chroma (partner accept or line-end flush).
// Backpressure: none; driven by the input pixel strobe, a pending pixel waits indefinitely and is flushed at line end.
module image_ycbcr422_ycbcr444 #(
  parameter bit         CB_FIRST  = 1'b1,
  parameter logic [7:0] C_DEFAULT = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  input  logic [7:0] per_img_C,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,
  output logic [7:0] post_img_Cb,
  output logic [7:0] post_img_Cr
);

  // Framing delay lines
  logic [1:0] vsync_p_q, vsync_p_d;
  logic [1:0] href_p_q,  href_p_d;

  // Line state: parity of the next accepted pixel, and the one pixel awaiting emission
  logic       parity_q,     parity_d;
  logic       pending_q,    pending_d;
  logic       pend_odd_q,   pend_odd_d;
  logic       pair_valid_q, pair_valid_d;
  logic [7:0] y_hold_q,     y_hold_d;
  logic [7:0] c0_q,         c0_d;

  // Chroma of the last complete pair, in arrival order (first, second)
  logic [7:0] pair_c0_q, pair_c0_d;
  logic [7:0] pair_c1_q, pair_c1_d;

  // Output registers
  logic       out_vld_q, out_vld_d;
  logic [7:0] out_y_q,   out_y_d;
  logic [7:0] out_cb_q,  out_cb_d;
  logic [7:0] out_cr_q,  out_cr_d;

  logic       accept;
  logic [7:0] emit_y;
  logic [7:0] emit_first;
  logic [7:0] emit_second;

  assign accept = per_frame_clken & per_frame_href;

  // Next-state: pairing, emission selection and end-of-line flush
  always_comb begin
    vsync_p_d    = {vsync_p_q[0], per_frame_vsync};
    href_p_d     = {href_p_q[0], per_frame_href};
    parity_d     = parity_q;
    pending_d    = pending_q;
    pend_odd_d   = pend_odd_q;
    pair_valid_d = pair_valid_q;
    y_hold_d     = y_hold_q;
    c0_d         = c0_q;
    pair_c0_d    = pair_c0_q;
    pair_c1_d    = pair_c1_q;
    out_vld_d    = 1'b0;
    out_y_d      = out_y_q;
    out_cb_d     = out_cb_q;
    out_cr_d     = out_cr_q;
    emit_y       = y_hold_q;
    emit_first   = pair_c0_q;
    emit_second  = pair_c1_q;

    if (accept) begin
      if (!parity_q) begin
        // Even pixel: the previous odd pixel (if any) already owns complete pair chroma
        if (pending_q) begin
          out_vld_d = 1'b1;
        end
        y_hold_d   = per_img_Y;
        c0_d       = per_img_C;
        pending_d  = 1'b1;
        pend_odd_d = 1'b0;
        parity_d   = 1'b1;
      end else begin
        // Odd pixel completes the pair; the held even pixel goes out with it
        out_vld_d    = 1'b1;
        emit_first   = c0_q;
        emit_second  = per_img_C;
        pair_c0_d    = c0_q;
        pair_c1_d    = per_img_C;
        y_hold_d     = per_img_Y;
        pair_valid_d = 1'b1;
        pending_d    = 1'b1;
        pend_odd_d   = 1'b1;
        parity_d     = 1'b0;
      end
    end else if (!per_frame_href) begin
      // Outside a line: flush whatever is held, then start the next line clean
      if (pending_q) begin
        out_vld_d = 1'b1;
        if (!pend_odd_q) begin
          // Unpaired last pixel keeps its own chroma and borrows the other component
          emit_first  = c0_q;
          emit_second = pair_valid_q ? pair_c1_q : C_DEFAULT;
        end
      end
      pending_d    = 1'b0;
      pair_valid_d = 1'b0;
      parity_d     = 1'b0;
    end

    if (out_vld_d) begin
      out_y_d  = emit_y;
      out_cb_d = CB_FIRST ? emit_first  : emit_second;
      out_cr_d = CB_FIRST ? emit_second : emit_first;
    end
  end

  // State and output registers, cleared by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p_q    <= '0;
      href_p_q     <= '0;
      parity_q     <= 1'b0;
      pending_q    <= 1'b0;
      pend_odd_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      y_hold_q     <= '0;
      c0_q         <= '0;
      pair_c0_q    <= '0;
      pair_c1_q    <= '0;
      out_vld_q    <= 1'b0;
      out_y_q      <= '0;
      out_cb_q     <= '0;
      out_cr_q     <= '0;
    end else begin
      vsync_p_q    <= vsync_p_d;
      href_p_q     <= href_p_d;
      parity_q     <= parity_d;
      pending_q    <= pending_d;
      pend_odd_q   <= pend_odd_d;
      pair_valid_q <= pair_valid_d;
      y_hold_q     <= y_hold_d;
      c0_q         <= c0_d;
      pair_c0_q    <= pair_c0_d;
      pair_c1_q    <= pair_c1_d;
      out_vld_q    <= out_vld_d;
      out_y_q      <= out_y_d;
      out_cb_q     <= out_cb_d;
      out_cr_q     <= out_cr_d;
    end
  end

  assign post_frame_vsync = vsync_p_q[1];
  assign post_frame_href  = href_p_q[1];
  assign post_frame_clken = out_vld_q;
  assign post_img_Y       = href_p_q[1] ? out_y_q  : 8'd0;
  assign post_img_Cb      = href_p_q[1] ? out_cb_q : 8'd0;
  assign post_img_Cr      = href_p_q[1] ? out_cr_q : 8'd0;

endmodule

// File: tb/tb_image_ycbcr422_ycbcr444.sv
// Bench for the 4:2:2 to 4:4:4 upsampler: two instances (Cb-first and Cr-first) share one stimulus.
// Emitted pixels are collected into queues and compared against a pair-based reference model.
// Framing delays and output masking are compared cycle by cycle from recorded histories.
module tb_image_ycbcr422_ycbcr444;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [7:0] y_in = '0, c_in = '0;

  logic       a_vs, a_hr, a_ck, b_vs, b_hr, b_ck;
  logic [7:0] a_y, a_cb, a_cr, b_y, b_cb, b_cr;

  always #5 clk = ~clk;

  image_ycbcr422_ycbcr444 #(.CB_FIRST(1'b1), .C_DEFAULT(8'd128)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(y_in), .per_img_C(c_in),
    .post_frame_vsync(a_vs), .post_frame_href(a_hr), .post_frame_clken(a_ck),
    .post_img_Y(a_y), .post_img_Cb(a_cb), .post_img_Cr(a_cr)
  );

  image_ycbcr422_ycbcr444 #(.CB_FIRST(1'b0), .C_DEFAULT(8'd128)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(y_in), .per_img_C(c_in),
    .post_frame_vsync(b_vs), .post_frame_href(b_hr), .post_frame_clken(b_ck),
    .post_img_Y(b_y), .post_img_Cb(b_cb), .post_img_Cr(b_cr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;

  typedef struct {logic [7:0] y; logic [7:0] cb; logic [7:0] cr; int cyc;} px_t;
  px_t a_q[$];
  px_t b_q[$];
  int  acc_cyc[$];

  logic [7:0] line_y [0:15];
  logic [7:0] line_c [0:15];
  logic [7:0] exp_y  [0:15];
  logic [7:0] exp_cb [0:15];
  logic [7:0] exp_cr [0:15];

  logic in_hr [0:8191];
  logic in_vs [0:8191];
  logic out_hr[0:8191];
  logic out_vs[0:8191];
  logic mask_ok[0:8191];

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted input pixels and the input framing as seen by the sampling edge
  always @(posedge clk) begin
    in_hr[cyc % 8192] <= href;
    in_vs[cyc % 8192] <= vsync;
    if (rst_n && href && clken) acc_cyc.push_back(cyc);
  end

  // Collect emitted pixels and output framing mid-cycle
  always @(negedge clk) begin
    if (a_ck) a_q.push_back('{a_y, a_cb, a_cr, cyc});
    if (b_ck) b_q.push_back('{b_y, b_cb, b_cr, cyc});
    out_hr[cyc % 8192]  <= a_hr;
    out_vs[cyc % 8192]  <= a_vs;
    mask_ok[cyc % 8192] <= (a_hr || (a_y == 0 && a_cb == 0 && a_cr == 0)) &&
                           (b_hr || (b_y == 0 && b_cb == 0 && b_cr == 0));
  end

  // Reference: each pixel takes the chroma of its pair; an unpaired last pixel keeps its
  // own chroma and borrows the other component from the previous pair, or 128 if none.
  task automatic build_expected(input bit cb_first, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      logic [7:0] first, second;
      k = i / 2;
      first = line_c[2*k];
      if (2*k + 1 < n) second = line_c[2*k + 1];
      else if (k > 0)  second = line_c[2*k - 1];
      else             second = 8'd128;
      exp_y[i]  = line_y[i];
      exp_cb[i] = cb_first ? first : second;
      exp_cr[i] = cb_first ? second : first;
    end
  endtask

  task automatic clear_queues();
    a_q.delete();
    b_q.delete();
    acc_cyc.delete();
  endtask

  task automatic idle(input int n);
    href = 1'b0;
    clken = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one line of n pixels from line_y/line_c; idle cycles carry junk data with clken=0
  task automatic drive_line(input int n, input int gap, input bit rnd_gap);
    int g;
    href = 1'b1;
    for (int i = 0; i < n; i++) begin
      clken = 1'b1; y_in = line_y[i]; c_in = line_c[i];
      vsync = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      clken = 1'b0; y_in = 8'($urandom); c_in = 8'($urandom);
      g = rnd_gap ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin @(posedge clk); #1; end
    end
    href = 1'b0;
    clken = 1'($urandom_range(0, 1));
    fall_cyc = cyc;
    @(posedge clk); #1;
    clken = 1'b0;
  endtask

  task automatic test_reset();
    href = 1'b1; clken = 1'b1; vsync = 1'b1; y_in = 8'hAA; c_in = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_vs, a_hr, a_ck, a_y, a_cb, a_cr} !== 27'd0 || {b_vs, b_hr, b_ck, b_y, b_cb, b_cr} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got a=%h b=%h want 0", {a_vs, a_hr, a_ck, a_y, a_cb, a_cr},
               {b_vs, b_hr, b_ck, b_y, b_cb, b_cr});
    end
    @(posedge clk); #1;
    href = 1'b0; clken = 1'b0; vsync = 1'b0;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_four_pixel();
    logic [7:0] ecb[4];
    logic [7:0] ecr[4];
    ecb[0] = 100; ecb[1] = 100; ecb[2] = 101; ecb[3] = 101;
    ecr[0] = 200; ecr[1] = 200; ecr[2] = 201; ecr[3] = 201;
    for (int i = 0; i < 4; i++) line_y[i] = 8'(10 + i);
    line_c[0] = 100; line_c[1] = 200; line_c[2] = 101; line_c[3] = 201;
    clear_queues();
    drive_line(4, 0, 1'b0);
    idle(3);
    checks++;
    if (a_q.size() != 4 || b_q.size() != 4) begin
      errors++;
      $display("FAIL four_count got a=%0d b=%0d want 4", a_q.size(), b_q.size());
    end
    for (int i = 0; i < 4 && i < a_q.size() && i < b_q.size(); i++) begin
      checks++;
      if (a_q[i].y !== line_y[i] || a_q[i].cb !== ecb[i] || a_q[i].cr !== ecr[i]) begin
        errors++;
        $display("FAIL four_cbfirst[%0d] got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                 a_q[i].y, a_q[i].cb, a_q[i].cr, line_y[i], ecb[i], ecr[i]);
      end
      checks++;
      if (b_q[i].y !== line_y[i] || b_q[i].cb !== ecr[i] || b_q[i].cr !== ecb[i]) begin
        errors++;
        $display("FAIL four_crfirst[%0d] got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                 b_q[i].y, b_q[i].cb, b_q[i].cr, line_y[i], ecr[i], ecb[i]);
      end
    end
    if (a_q.size() == 4) begin
      checks++;
      if (a_q[3].cyc != fall_cyc + 1) begin
        errors++;
        $display("FAIL four_flush_time got %0d want %0d", a_q[3].cyc, fall_cyc + 1);
      end
    end
  endtask

  task automatic test_odd_lines();
    line_y[0] = 1; line_y[1] = 2; line_y[2] = 3;
    line_c[0] = 50; line_c[1] = 60; line_c[2] = 70;
    clear_queues();
    drive_line(3, 0, 1'b0);
    idle(3);
    build_expected(1'b1, 3);
    checks++;
    if (a_q.size() != 3) begin
      errors++;
      $display("FAIL three_count got %0d want 3", a_q.size());
    end else begin
      checks++;
      if (a_q[2].y !== 8'd3 || a_q[2].cb !== 8'd70 || a_q[2].cr !== 8'd60) begin
        errors++;
        $display("FAIL three_last got (%0d,%0d,%0d) want (3,70,60)", a_q[2].y, a_q[2].cb, a_q[2].cr);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (a_q[i].y !== exp_y[i] || a_q[i].cb !== exp_cb[i] || a_q[i].cr !== exp_cr[i]) begin
          errors++;
          $display("FAIL three_pix[%0d] got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                   a_q[i].y, a_q[i].cb, a_q[i].cr, exp_y[i], exp_cb[i], exp_cr[i]);
        end
      end
    end

    line_y[0] = 9; line_c[0] = 77;
    clear_queues();
    drive_line(1, 0, 1'b0);
    idle(3);
    checks++;
    if (a_q.size() != 1 || b_q.size() != 1) begin
      errors++;
      $display("FAIL one_count got a=%0d b=%0d want 1", a_q.size(), b_q.size());
    end else begin
      checks++;
      if (a_q[0].y !== 8'd9 || a_q[0].cb !== 8'd77 || a_q[0].cr !== 8'd128 ||
          b_q[0].y !== 8'd9 || b_q[0].cb !== 8'd128 || b_q[0].cr !== 8'd77) begin
        errors++;
        $display("FAIL one_pix got a=(%0d,%0d,%0d) b=(%0d,%0d,%0d) want a=(9,77,128) b=(9,128,77)",
                 a_q[0].y, a_q[0].cb, a_q[0].cr, b_q[0].y, b_q[0].cb, b_q[0].cr);
      end
    end
  endtask

  task automatic test_gapped();
    int start_c, end_c;
    for (int i = 0; i < 4; i++) line_y[i] = 8'(10 + i);
    line_c[0] = 100; line_c[1] = 200; line_c[2] = 101; line_c[3] = 201;
    start_c = cyc;
    vsync = 1'b1;
    idle(2);
    vsync = 1'b0;
    clear_queues();
    drive_line(4, 2, 1'b0);
    idle(4);
    end_c = cyc;
    build_expected(1'b1, 4);
    checks++;
    if (a_q.size() != 4 || acc_cyc.size() != 4) begin
      errors++;
      $display("FAIL gap_count got strobes=%0d accepts=%0d want 4", a_q.size(), acc_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        int want_c;
        want_c = (i < 3) ? acc_cyc[i+1] + 1 : fall_cyc + 1;
        checks++;
        if (a_q[i].y !== exp_y[i] || a_q[i].cb !== exp_cb[i] || a_q[i].cr !== exp_cr[i] ||
            a_q[i].cyc != want_c) begin
          errors++;
          $display("FAIL gap_pix[%0d] got (%0d,%0d,%0d)@%0d want (%0d,%0d,%0d)@%0d", i,
                   a_q[i].y, a_q[i].cb, a_q[i].cr, a_q[i].cyc, exp_y[i], exp_cb[i], exp_cr[i], want_c);
        end
      end
    end
    for (int c = start_c + 2; c < end_c - 1; c++) begin
      checks++;
      if (out_hr[c % 8192] !== in_hr[(c-2) % 8192] || out_vs[c % 8192] !== in_vs[(c-2) % 8192] ||
          mask_ok[c % 8192] !== 1'b1) begin
        errors++;
        $display("FAIL gap_framing@%0d got hr=%b vs=%b mask=%b want hr=%b vs=%b mask=1", c,
                 out_hr[c % 8192], out_vs[c % 8192], mask_ok[c % 8192],
                 in_hr[(c-2) % 8192], in_vs[(c-2) % 8192]);
      end
    end
  endtask

  task automatic test_random();
    for (int l = 0; l < 10; l++) begin
      int n;
      n = int'($urandom_range(1, 9));
      for (int i = 0; i < n; i++) begin
        line_y[i] = 8'($urandom);
        line_c[i] = 8'($urandom);
      end
      clear_queues();
      drive_line(n, 0, 1'b1);
      idle(3);
      checks++;
      if (a_q.size() != n || b_q.size() != n) begin
        errors++;
        $display("FAIL rand_count line %0d got a=%0d b=%0d want %0d", l, a_q.size(), b_q.size(), n);
      end
      build_expected(1'b1, n);
      for (int i = 0; i < n && i < a_q.size(); i++) begin
        checks++;
        if (a_q[i].y !== exp_y[i] || a_q[i].cb !== exp_cb[i] || a_q[i].cr !== exp_cr[i]) begin
          errors++;
          $display("FAIL rand_a line %0d pix %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", l, i,
                   a_q[i].y, a_q[i].cb, a_q[i].cr, exp_y[i], exp_cb[i], exp_cr[i]);
        end
      end
      build_expected(1'b0, n);
      for (int i = 0; i < n && i < b_q.size(); i++) begin
        checks++;
        if (b_q[i].y !== exp_y[i] || b_q[i].cb !== exp_cb[i] || b_q[i].cr !== exp_cr[i]) begin
          errors++;
          $display("FAIL rand_b line %0d pix %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", l, i,
                   b_q[i].y, b_q[i].cb, b_q[i].cr, exp_y[i], exp_cb[i], exp_cr[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wy[6];
    logic [7:0] wcb[6];
    logic [7:0] wcr[6];
    for (int i = 0; i < 4; i++) begin
      line_y[i] = 8'($urandom);
      line_c[i] = 8'($urandom);
    end
    build_expected(1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      wy[i] = exp_y[i]; wcb[i] = exp_cb[i]; wcr[i] = exp_cr[i];
    end
    clear_queues();
    drive_line(4, 0, 1'b0);
    // Second line follows after a single low cycle; stop mid-pair after pixel 2
    for (int i = 0; i < 3; i++) begin
      line_y[i] = 8'($urandom);
      line_c[i] = 8'($urandom);
    end
    wy[4] = line_y[0]; wcb[4] = line_c[0]; wcr[4] = line_c[1];
    wy[5] = line_y[1]; wcb[5] = line_c[0]; wcr[5] = line_c[1];
    href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clken = 1'b1; y_in = line_y[i]; c_in = line_c[i];
      @(posedge clk); #1;
    end
    clken = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    href = 1'b0;
    #1;
    checks++;
    if ({a_vs, a_hr, a_ck, a_y, a_cb, a_cr} !== 27'd0) begin
      errors++;
      $display("FAIL b2b_reset_outputs got %h want 0", {a_vs, a_hr, a_ck, a_y, a_cb, a_cr});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    checks++;
    if (a_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d want 6", a_q.size());
    end
    for (int i = 0; i < 6 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i].y !== wy[i] || a_q[i].cb !== wcb[i] || a_q[i].cr !== wcr[i]) begin
        errors++;
        $display("FAIL b2b_pix[%0d] got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                 a_q[i].y, a_q[i].cb, a_q[i].cr, wy[i], wcb[i], wcr[i]);
      end
    end
    // Fresh line after reset
    for (int i = 0; i < 5; i++) begin
      line_y[i] = 8'($urandom);
      line_c[i] = 8'($urandom);
    end
    build_expected(1'b1, 5);
    clear_queues();
    drive_line(5, 0, 1'b1);
    idle(3);
    checks++;
    if (a_q.size() != 5) begin
      errors++;
      $display("FAIL post_reset_count got %0d want 5", a_q.size());
    end
    for (int i = 0; i < 5 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i].y !== exp_y[i] || a_q[i].cb !== exp_cb[i] || a_q[i].cr !== exp_cr[i]) begin
        errors++;
        $display("FAIL post_reset_pix[%0d] got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                 a_q[i].y, a_q[i].cb, a_q[i].cr, exp_y[i], exp_cb[i], exp_cr[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_four_pixel();
    test_odd_lines();
    test_gapped();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_ycbcr422_ycbcr444.md
Name: image_ycbcr422_ycbcr444

Overview:
Chroma upsampler sitting directly upstream of the YCbCr444-to-RGB888 converter. It accepts a 4:2:2 pixel stream with one Y byte and one chroma byte per pixel, where chroma alternates Cb/Cr per pixel pair. It emits a 4:4:4 stream (Y, Cb, Cr per pixel) using nearest-neighbour chroma replication. The vsync/href/clken framing matches the converter's input interface, so the two blocks connect directly.

Parameters:
CB_FIRST, 1, 1: even pixel of a pair carries Cb and odd pixel carries Cr; 0: the reverse.
C_DEFAULT, 8'd128, chroma substituted when a pair's second chroma byte never arrives and no earlier pair exists in the line.

Ports:
clk  input  1  pixel clock
rst_n  input  1  reset, asynchronous, active-low
per_frame_vsync  input  1  input frame sync
per_frame_href  input  1  input line valid
per_frame_clken  input  1  input pixel strobe; counts only when href=1
per_img_Y  input  8  luma
per_img_C  input  8  interleaved chroma
post_frame_vsync  output  1  per_frame_vsync delayed exactly 2 clk
post_frame_href  output  1  per_frame_href delayed exactly 2 clk
post_frame_clken  output  1  one-clk strobe per emitted 4:4:4 pixel
post_img_Y  output  8  luma out
post_img_Cb  output  8  Cb out
post_img_Cr  output  8  Cr out

Behaviour:
- Reset (async): every register and output = 0; parity=even, pending=0, pair_valid=0.
- Accepted pixel = clken & href, sampled on clk rising edge. Y/C are ignored otherwise.
- Parity bit toggles per accepted pixel and clears while href=0, so index 0 of each line is even.
- Accepted even pixel 2k:
  - Store Y0=Y and the first chroma (Cb if CB_FIRST).
  - If pixel 2k-1 is pending, emit it using pair k-1 chroma.
  - pending=1 (holding 2k).
- Accepted odd pixel 2k+1:
  - Emit pixel 2k as (Y0, Cb_k, Cr_k), where the missing chroma is taken directly from the current input C.
  - Latch the pair chroma and Y1; pair_valid=1; pending=1 (holding 2k+1).
- Emission: output registers load on the edge that accepts the triggering pixel. post_frame_clken=1 for exactly the following clk. Data holds between strobes.
- Flush on first cycle with href=0 after href=1, if pending=1, with output on the next clk:
  - Pending odd pixel: emit with its pair chroma.
  - Pending even pixel (odd line length): use the second chroma from the last complete pair if pair_valid, else C_DEFAULT. Its own first chroma is kept.
  - Then clear pending, pair_valid and parity.
- Output order: pixel i is emitted exactly once, in order. The emission count per line equals the accepted-pixel count.
- Timing guarantees:
  - Emissions always fall within post_frame_href=1, since the first emission is at ≥ rise+2 and the flush output is at fall+1 ≤ fall+1.
  - The minimum href low gap is 1 clk; a flush and the next line's emissions never collide.
- post_img_* = 0 whenever post_frame_href=0; otherwise the register value.
- Gapped clken within a line: pending data waits indefinitely; no timeout.
- vsync is only delayed; it does not affect line state.
- Reset mid-line discards any pending pixel; no flush strobe is generated.
- Width rule: no arithmetic; pure selection and registering.

Test Plan:
- 4-pixel line, continuous clken, CB_FIRST=1; Y=10,11,12,13 and C=100,200,101,201 -> 4 strobes with (10,100,200), (11,100,200), (12,101,201), (13,101,201); the last is emitted at fall+1.
- 3-pixel line, Y=1,2,3 and C=50,60,70 -> third output is (3,70,60).
- 1-pixel line, Y=9 and C=77 -> single output (9,77,128).
- Gapped clken (1 pixel every 3 clk), 4 pixels -> same data as the first test.
  - Each strobe is 1 clk after the accepting edge.
  - post_frame_href and vsync are exact 2-clk delays.
- CB_FIRST=0 with the C sequence of the first test -> Cb/Cr swapped: (10,200,100), ….
- Two back-to-back lines with a 1-clk href gap, plus an async reset asserted mid-pixel-pair in the second line:
  - First line flush emitted correctly.
  - After reset, all outputs read 0 and no strobes occur until the next line.
  - A fresh line after reset produces correct data.
